// File: rtl/text_overlay_draw.sv
// text_overlay_draw: text-window overlay stage that addresses a text RAM / font ROM chain and merges glyph pixels into the RGB stream.
//
// Ports:
//   i_pclk, i_rst_n            pixel clock, asynchronous active-low reset
//   i_hcount/i_vcount          12-bit pixel coordinates
//   i_hsync/i_hblnk/i_vsync/i_vblnk, i_rgb   upstream timing and colour
//   i_rom_word                 glyph row byte returned by the font ROM (bit 7 = leftmost pixel)
//   i_hl_en, i_hl_row          highlight request, sampled once per frame on vsync rise
//   o_char_addr                {row, col} to text RAM (combinational, 0 outside window)
//   o_char_line                glyph line to font ROM (registered)
//   o_hcount..o_rgb            inputs delayed by 3 clocks, rgb merged with text
//
// Optional feature: define TEXT_OVERLAY_BLINK_EN to compile in the blink frame counter;
// otherwise the highlighted row is shown steadily.
module text_overlay_draw #(
    parameter int          XPOS         = 672,
    parameter int          YPOS         = 320,
    parameter int          COLS         = 72,
    parameter int          ROWS         = 12,
    parameter int          X_ADDR_WIDTH = 7,
    parameter int          Y_ADDR_WIDTH = 4,
    parameter int          SCALE_LOG2   = 0,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter bit          BG_OPAQUE    = 1'b0,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                                 i_pclk,
    input  logic                                 i_rst_n,
    input  logic [11:0]                          i_hcount,
    input  logic [11:0]                          i_vcount,
    input  logic                                 i_hsync,
    input  logic                                 i_hblnk,
    input  logic                                 i_vsync,
    input  logic                                 i_vblnk,
    input  logic [11:0]                          i_rgb,
    input  logic [7:0]                           i_rom_word,
    input  logic                                 i_hl_en,
    input  logic [Y_ADDR_WIDTH-1:0]              i_hl_row,
    output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] o_char_addr,
    output logic [3:0]                           o_char_line,
    output logic [11:0]                          o_hcount,
    output logic [11:0]                          o_vcount,
    output logic                                 o_hsync,
    output logic                                 o_hblnk,
    output logic                                 o_vsync,
    output logic                                 o_vblnk,
    output logic [11:0]                          o_rgb
);

    if (COLS > (1 << X_ADDR_WIDTH)) begin : g_cols_chk
        $error("COLS exceeds column address space");
    end
    if (ROWS > (1 << Y_ADDR_WIDTH)) begin : g_rows_chk
        $error("ROWS exceeds row address space");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_scale_chk
        $error("SCALE_LOG2 must be 0..2");
    end
    if (BLINK_FRAMES < 1) begin : g_blink_chk
        $error("BLINK_FRAMES must be at least 1");
    end

    localparam logic [11:0] XP = 12'(XPOS);
    localparam logic [11:0] YP = 12'(YPOS);
    // one bit wider so a window touching the 4096 boundary still compares correctly
    localparam logic [12:0] XE = 13'(XPOS + COLS * (8 << SCALE_LOG2));
    localparam logic [12:0] YE = 13'(YPOS + ROWS * (16 << SCALE_LOG2));

    typedef struct packed {
        logic [11:0]             hc;
        logic [11:0]             vc;
        logic                    hs;
        logic                    hb;
        logic                    vs;
        logic                    vb;
        logic [11:0]             rgb;
        logic                    win;
        logic [2:0]              bit_idx;
        logic [Y_ADDR_WIDTH-1:0] row;
    } stage_t;

    logic [11:0]             hrel;
    logic [11:0]             vrel;
    logic                    in_win;
    logic [X_ADDR_WIDTH-1:0] col;
    logic [Y_ADDR_WIDTH-1:0] row;
    stage_t                  st0;
    stage_t                  st1;
    stage_t                  st2;
    logic                    vs_d;
    logic                    vs_rise;
    logic                    hl_en_q;
    logic [Y_ADDR_WIDTH-1:0] hl_row_q;
    logic                    blink_on;
    logic                    pix_set;
    logic                    hl_hit;
    logic [11:0]             rgb_nxt;

    assign hrel    = i_hcount - XP;
    assign vrel    = i_vcount - YP;
    assign in_win  = (i_hcount >= XP) && ({1'b0, i_hcount} < XE) &&
                     (i_vcount >= YP) && ({1'b0, i_vcount} < YE);
    assign col     = X_ADDR_WIDTH'(hrel >> (3 + SCALE_LOG2));
    assign row     = Y_ADDR_WIDTH'(vrel >> (4 + SCALE_LOG2));
    assign o_char_addr = in_win ? {row, col} : '0;
    assign st0     = {i_hcount, i_vcount, i_hsync, i_hblnk, i_vsync, i_vblnk, i_rgb,
                      in_win, 3'(hrel >> SCALE_LOG2), row};
    assign vs_rise = i_vsync && !vs_d;

    // two delay stages line the pixel data up with the RAM + ROM read latency
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st1         <= '0;
            st2         <= '0;
            o_char_line <= '0;
        end else begin
            st1         <= st0;
            st2         <= st1;
            o_char_line <= 4'(vrel >> SCALE_LOG2);
        end
    end

    // highlight request is frozen per frame so a mid-frame change cannot tear
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_d     <= 1'b0;
            hl_en_q  <= 1'b0;
            hl_row_q <= '0;
        end else begin
            vs_d <= i_vsync;
            if (vs_rise) begin
                hl_en_q  <= i_hl_en;
                hl_row_q <= i_hl_row;
            end
        end
    end

`ifdef TEXT_OVERLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (vs_rise) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_on = 1'b1;
`endif

    // bit 7 of the glyph byte is the leftmost pixel, hence the inverted index
    always_comb begin
        pix_set = i_rom_word[~st2.bit_idx];
        hl_hit  = hl_en_q && (st2.row == hl_row_q) && blink_on;
        rgb_nxt = (st2.hb || st2.vb) ? 12'h000 :
                  !st2.win           ? st2.rgb :
                  hl_hit             ? (pix_set ? BG_COLOR : FG_COLOR) :
                  pix_set            ? FG_COLOR :
                  BG_OPAQUE          ? BG_COLOR : st2.rgb;
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hcount <= '0;
            o_vcount <= '0;
            o_hsync  <= 1'b0;
            o_hblnk  <= 1'b0;
            o_vsync  <= 1'b0;
            o_vblnk  <= 1'b0;
            o_rgb    <= '0;
        end else begin
            o_hcount <= st2.hc;
            o_vcount <= st2.vc;
            o_hsync  <= st2.hs;
            o_hblnk  <= st2.hb;
            o_vsync  <= st2.vs;
            o_vblnk  <= st2.vb;
            o_rgb    <= rgb_nxt;
        end
    end

endmodule
